f1_reaction_ctrl: RTL and testbench
===================================

# f1_reaction_ctrl

Sequences the random-delay and reaction-timing phase of the F1 start-light controller. Once all start lights are lit, it loads a pseudo-random hold time from the LFSR and counts it down in millisecond ticks. It then signals lights-out, measures the driver's reaction time and detects false starts. It sits between the light-sequencing FSM, the free-running LFSR, the ms tick generator and the result display logic.

## Interface
- DELAY_MIN_MS, 250: minimum lights-on hold time in ms.
- RT_MAX, 9999: reaction-time saturation value in ms; no-response limit.
- sysclk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tick_ms  in  1  one-cycle pulse every 1 ms.
- lights_on  in  1  high while all start lights are lit; only its rising edge is used.
- lfsr_val  in  14  current LFSR value.
- button  in  1  driver button, already synchronised, level.
- clear_best  in  1  clears the best-time register.
- en_lfsr  out  1  LFSR run enable.
- time_out  out  1  one-cycle lights-out pulse to the light FSM.
- busy  out  1  high in WAIT and MEASURE.
- rt_valid  out  1  rt_ms holds a completed measurement.
- false_start  out  1  button was pressed before lights-out.
- rt_ms  out  14  last reaction time in ms.
- best_ms  out  14  best valid reaction time in ms.
- best_valid  out  1  best_ms is meaningful.

## Operation
- States: IDLE, WAIT, MEASURE, DONE, FAULT.
- rise = lights_on & ~lights_on_q, where lights_on_q is a registered copy of lights_on. A rise is acted on only in IDLE, DONE or FAULT; it is ignored in WAIT and MEASURE.
- IDLE/DONE/FAULT + rise:
  - dly_cnt <= DELAY_MIN_MS + lfsr_val[10:0] (12-bit, range DELAY_MIN_MS..DELAY_MIN_MS+2047).
  - Clear rt_valid, false_start, rt_ms.
  - Go to WAIT.
- WAIT:
  - A tick_ms with dly_cnt > 1 decrements dly_cnt.
  - A tick_ms with dly_cnt == 1 goes to MEASURE, clears rt_cnt and pulses time_out.
  - button == 1 in any WAIT cycle goes to FAULT, sets false_start and pulses time_out. button has priority over a coincident final tick.
- MEASURE:
  - tick_ms increments rt_cnt, saturating at RT_MAX.
  - button == 1: rt_ms <= rt_cnt, using the pre-increment value when a tick coincides. Set rt_valid and go to DONE.
  - Best update: if !best_valid or rt_cnt < best_ms, then best_ms <= rt_cnt and best_valid <= 1.
  - If rt_cnt == RT_MAX and button == 0: rt_ms <= RT_MAX, set rt_valid, go to DONE. No best update in this case.
- DONE/FAULT: results are held until the next rise or rst. No transition back to IDLE is required.
- en_lfsr = 1 in IDLE, DONE and FAULT; 0 in WAIT and MEASURE (Moore). The LFSR is frozen while timing.
- busy = 1 in WAIT and MEASURE.
- clear_best in any state: best_ms <= 0, best_valid <= 0. clear_best has priority over a coincident best update.
- rst in any state:
  - State goes to IDLE.
  - All registers are cleared, including best_ms, best_valid and lights_on_q.
- Arithmetic is unsigned, with no wrap: dly_cnt never underflows and rt_cnt saturates.

## Timing
- Reset values: en_lfsr=1; all other outputs 0.
- A rise sampled at cycle N: lfsr_val is captured at N, and busy=1 and en_lfsr=0 from N+1.
- Delay length: time_out is high in the cycle after the D-th tick_ms, where D = loaded dly_cnt. It is high for exactly one cycle, and state = MEASURE in that same cycle.
- Measurement: rt_valid, rt_ms and the best_ms update are visible in the cycle after button is sampled high.
- Resolution: rt_ms counts whole ms ticks after lights-out. A press before the first tick gives rt_ms = 0.
- False start: false_start and time_out are both visible in the cycle after button is sampled high in WAIT.

## Test plan
- Reset: assert rst for 2 cycles mid-MEASURE. Required: IDLE, en_lfsr=1, busy=0, and rt_valid, false_start, best_valid, time_out all 0.
- Normal run:
  - Setup: DELAY_MIN_MS=3, lfsr_val=14'h0005, then raise lights_on.
  - Required: time_out pulses once, 1 cycle after the 8th tick.
  - Then press button after 123 ticks. Required: rt_ms=123, rt_valid=1, best_ms=123, best_valid=1.
- Best tracking: repeat with reactions of 200, then 50. Required: best_ms stays 123 after the 200 run, then becomes 50.
- False start: press button after tick 4 of an 8-tick WAIT. Required: false_start=1, one time_out pulse, rt_valid=0, best unchanged, en_lfsr=1.
- No response: RT_MAX=20, never press button. Required: rt_ms=20, rt_valid=1, best unchanged.
- Coincident events:
  - button and tick_ms in the same cycle with rt_cnt=9. Required: rt_ms=9.
  - clear_best together with a best update. Required: best_valid=0.
  - A rise during WAIT. Required: ignored, dly_cnt is not reloaded.

Source files
------------

// File: rtl/f1_reaction_ctrl.sv
// f1_reaction_ctrl: random lights-on hold, lights-out pulse, reaction timing and best-time tracking
module f1_reaction_ctrl #(
    parameter int DELAY_MIN_MS = 250,
    parameter int RT_MAX       = 9999
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        tick_ms,
    input  logic        lights_on,
    input  logic [13:0] lfsr_val,
    input  logic        button,
    input  logic        clear_best,
    output logic        en_lfsr,
    output logic        time_out,
    output logic        busy,
    output logic        rt_valid,
    output logic        false_start,
    output logic [13:0] rt_ms,
    output logic [13:0] best_ms,
    output logic        best_valid
);
    typedef enum logic [2:0] {IDLE, WAIT, MEASURE, DONE, FAULT} state_t;
    localparam logic [11:0] DMIN_V   = 12'(DELAY_MIN_MS);
    localparam logic [13:0] RT_MAX_V = 14'(RT_MAX);
    state_t      state_q, state_d;
    logic        lights_on_q, time_out_q, rt_valid_q, false_start_q, best_valid_q;
    logic [11:0] dly_cnt_q;
    logic [13:0] rt_cnt_q, rt_ms_q, best_ms_q;
    logic        rise, last_tick, rt_sat, unused_lfsr;
    assign rise        = lights_on & ~lights_on_q;
    assign last_tick   = tick_ms && dly_cnt_q <= 12'd1;
    assign rt_sat      = rt_cnt_q == RT_MAX_V;
    assign unused_lfsr = ^lfsr_val[13:11];
    assign time_out    = time_out_q;
    assign rt_valid    = rt_valid_q;
    assign false_start = false_start_q;
    assign rt_ms       = rt_ms_q;
    assign best_ms     = best_ms_q;
    assign best_valid  = best_valid_q;
    // state register
    always_ff @(posedge sysclk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // next state: a false start beats the final tick, a press beats saturation
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT:    state_d = button ? FAULT : (last_tick ? MEASURE : WAIT);
            MEASURE: state_d = (button || rt_sat) ? DONE : MEASURE;
            default: state_d = rise ? WAIT : state_q;
        endcase
    end
    // Moore outputs: LFSR frozen while timing
    always_comb begin
        busy    = state_q == WAIT || state_q == MEASURE;
        en_lfsr = !busy;
    end
    // delay countdown, reaction counter, results and best time
    always_ff @(posedge sysclk) begin
        if (rst) begin
            lights_on_q   <= 1'b0;
            time_out_q    <= 1'b0;
            dly_cnt_q     <= '0;
            rt_cnt_q      <= '0;
            rt_ms_q       <= '0;
            rt_valid_q    <= 1'b0;
            false_start_q <= 1'b0;
            best_ms_q     <= '0;
            best_valid_q  <= 1'b0;
        end else begin
            lights_on_q <= lights_on;
            time_out_q  <= 1'b0;
            if (!busy && rise) begin
                dly_cnt_q     <= DMIN_V + {1'b0, lfsr_val[10:0]};
                rt_valid_q    <= 1'b0;
                false_start_q <= 1'b0;
                rt_ms_q       <= '0;
            end
            if (state_q == WAIT) begin
                if (button) begin
                    false_start_q <= 1'b1;
                    time_out_q    <= 1'b1;
                end else if (last_tick) begin
                    rt_cnt_q   <= '0;
                    time_out_q <= 1'b1;
                end else if (tick_ms) begin
                    dly_cnt_q <= dly_cnt_q - 12'd1;
                end
            end
            if (state_q == MEASURE) begin
                if (button) begin
                    rt_ms_q    <= rt_cnt_q;
                    rt_valid_q <= 1'b1;
                    if (!best_valid_q || rt_cnt_q < best_ms_q) begin
                        best_ms_q    <= rt_cnt_q;
                        best_valid_q <= 1'b1;
                    end
                end else if (rt_sat) begin
                    rt_ms_q    <= RT_MAX_V;
                    rt_valid_q <= 1'b1;
                end else if (tick_ms) begin
                    rt_cnt_q <= rt_cnt_q + 14'd1;
                end
            end
            if (clear_best) begin
                best_ms_q    <= '0;
                best_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_f1_reaction_ctrl.sv
// tb_f1_reaction_ctrl: run-level reference model checking two instances (long and short RT_MAX)
module tb_f1_reaction_ctrl;
    logic        sysclk = 1'b0;
    logic        rst, tick_ms, lights_on, button, clear_best;
    logic [13:0] lfsr_val;
    logic        en_lfsr_w[2], time_out_w[2], busy_w[2], rt_valid_w[2], false_start_w[2], best_valid_w[2];
    logic [13:0] rt_ms_w[2], best_ms_w[2];
    int          checks = 0, errors = 0;
    int          to_cnt[2];
    int          exp_best[2];
    bit          exp_bv[2];
    int          rtmax[2] = '{9999, 20};

    always #5 sysclk = ~sysclk;

    f1_reaction_ctrl #(.DELAY_MIN_MS(3)) dut0 (
        .sysclk(sysclk), .rst(rst), .tick_ms(tick_ms), .lights_on(lights_on), .lfsr_val(lfsr_val),
        .button(button), .clear_best(clear_best), .en_lfsr(en_lfsr_w[0]), .time_out(time_out_w[0]),
        .busy(busy_w[0]), .rt_valid(rt_valid_w[0]), .false_start(false_start_w[0]), .rt_ms(rt_ms_w[0]),
        .best_ms(best_ms_w[0]), .best_valid(best_valid_w[0])
    );
    f1_reaction_ctrl #(.DELAY_MIN_MS(3), .RT_MAX(20)) dut1 (
        .sysclk(sysclk), .rst(rst), .tick_ms(tick_ms), .lights_on(lights_on), .lfsr_val(lfsr_val),
        .button(button), .clear_best(clear_best), .en_lfsr(en_lfsr_w[1]), .time_out(time_out_w[1]),
        .busy(busy_w[1]), .rt_valid(rt_valid_w[1]), .false_start(false_start_w[1]), .rt_ms(rt_ms_w[1]),
        .best_ms(best_ms_w[1]), .best_valid(best_valid_w[1])
    );

    task automatic cyc();
        @(posedge sysclk);
        #1;
        for (int i = 0; i < 2; i++) if (time_out_w[i] === 1'b1) to_cnt[i]++;
    endtask

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[dut%0d] observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 1)) cyc();
    endtask

    task automatic tick();
        tick_ms = 1'b1;
        cyc();
        tick_ms = 1'b0;
    endtask

    task automatic chk_best();
        for (int i = 0; i < 2; i++) begin
            chk("best_ms", i, best_ms_w[i], exp_best[i]);
            chk("best_valid", i, best_valid_w[i], exp_bv[i]);
        end
    endtask

    // fs_tick >= 0: false start after that many WAIT ticks; else react = MEASURE ticks before press
    task automatic run(input logic [13:0] lv, input int fs_tick, input int react, input bit coin,
                       input bit clr, input bit rerise);
        int d, nt, er;
        d  = 3 + int'(lv[10:0]);
        nt = (fs_tick >= 0) ? fs_tick : d;
        lights_on = 1'b0;
        cyc();
        lights_on = 1'b1;
        lfsr_val  = lv;
        cyc();
        lfsr_val  = 14'($urandom);
        to_cnt    = '{0, 0};
        for (int i = 0; i < 2; i++) begin
            chk("busy_after_rise", i, busy_w[i], 1);
            chk("en_lfsr_after_rise", i, en_lfsr_w[i], 0);
            chk("rt_valid_cleared", i, rt_valid_w[i], 0);
            chk("false_start_cleared", i, false_start_w[i], 0);
        end
        for (int k = 1; k <= nt; k++) begin
            tick();
            if (k == d) for (int i = 0; i < 2; i++) chk("time_out_at_D", i, time_out_w[i], 1);
            if (k == d - 1) for (int i = 0; i < 2; i++) chk("no_early_time_out", i, to_cnt[i], 0);
            if (rerise && k == 2) begin
                lights_on = 1'b0;
                cyc();
                lights_on = 1'b1;
                lfsr_val  = 14'h07FF;
                cyc();
            end
            if (k < d) gap();
        end
        if (fs_tick >= 0) begin
            tick_ms = coin;
            button  = 1'b1;
            cyc();
            tick_ms = 1'b0;
            button  = 1'b0;
            for (int i = 0; i < 2; i++) begin
                chk("false_start", i, false_start_w[i], 1);
                chk("fs_time_out", i, time_out_w[i], 1);
                chk("fs_rt_valid", i, rt_valid_w[i], 0);
                chk("fs_en_lfsr", i, en_lfsr_w[i], 1);
            end
            chk_best();
            cyc();
            for (int i = 0; i < 2; i++) chk("fs_time_out_count", i, to_cnt[i], 1);
            return;
        end
        gap();
        for (int m = 0; m < react; m++) begin
            tick();
            gap();
        end
        tick_ms    = coin;
        button     = 1'b1;
        clear_best = clr;
        cyc();
        tick_ms    = 1'b0;
        button     = 1'b0;
        clear_best = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (react < rtmax[i]) begin
                er = react;
                if (!exp_bv[i] || react < exp_best[i]) begin
                    exp_best[i] = react;
                    exp_bv[i]   = 1'b1;
                end
            end else er = rtmax[i];
            if (clr) begin
                exp_best[i] = 0;
                exp_bv[i]   = 1'b0;
            end
            chk("rt_ms", i, rt_ms_w[i], er);
            chk("rt_valid", i, rt_valid_w[i], 1);
            chk("no_false_start", i, false_start_w[i], 0);
            chk("busy_done", i, busy_w[i], 0);
            chk("time_out_count", i, to_cnt[i], 1);
        end
        chk_best();
    endtask

    initial begin
        int r, fs;
        logic [13:0] lv;
        rst        = 1'b1;
        tick_ms    = 1'b0;
        lights_on  = 1'b0;
        button     = 1'b0;
        clear_best = 1'b0;
        lfsr_val   = '0;
        exp_best   = '{0, 0};
        exp_bv     = '{0, 0};
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_en_lfsr", i, en_lfsr_w[i], 1);
            chk("rst_busy", i, busy_w[i], 0);
            chk("rst_time_out", i, time_out_w[i], 0);
            chk("rst_rt_valid", i, rt_valid_w[i], 0);
            chk("rst_rt_ms", i, rt_ms_w[i], 0);
        end
        chk_best();
        run(14'h0005, -1, 123, 1'b0, 1'b0, 1'b0);
        run(14'h0005, -1, 200, 1'b0, 1'b0, 1'b0);
        run(14'h0005, -1, 50, 1'b0, 1'b0, 1'b0);
        run(14'h0005, 4, 0, 1'b0, 1'b0, 1'b0);
        run(14'h0005, 7, 0, 1'b1, 1'b0, 1'b0);
        run(14'h3803, -1, 25, 1'b0, 1'b0, 1'b0);
        run(14'h0002, -1, 9, 1'b1, 1'b0, 1'b0);
        run(14'h0004, -1, 7, 1'b0, 1'b1, 1'b0);
        run(14'h0005, -1, 15, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            lv = {3'($urandom), 11'($urandom_range(0, 60))};
            r  = $urandom_range(0, 60);
            if (r == 20) r = 21;
            fs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 + int'(lv[10:0])) : -1;
            run(lv, fs, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), 1'b0);
        end
        lights_on = 1'b0;
        cyc();
        lights_on = 1'b1;
        lfsr_val  = 14'h0000;
        cyc();
        repeat (5) tick();
        rst = 1'b1;
        cyc();
        cyc();
        rst       = 1'b0;
        lights_on = 1'b0;
        exp_best  = '{0, 0};
        exp_bv    = '{0, 0};
        for (int i = 0; i < 2; i++) begin
            chk("midrst_en_lfsr", i, en_lfsr_w[i], 1);
            chk("midrst_busy", i, busy_w[i], 0);
            chk("midrst_rt_valid", i, rt_valid_w[i], 0);
            chk("midrst_false_start", i, false_start_w[i], 0);
            chk("midrst_time_out", i, time_out_w[i], 0);
        end
        chk_best();
        run(14'h1001, -1, 0, 1'b0, 1'b0, 1'b0);
        run(14'h0006, -1, 30, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
